// File: rtl/vga_text_console_writer.sv
`default_nettype none
// ============================================================================
// Module   : vga_text_console_writer
// Purpose  : Terminal engine for a text-mode VGA frame buffer. Interprets a
//            byte stream (printable / CR / LF / BS / FF) and issues word
//            reads and writes on a valid/ready master bus, including
//            scroll-up and clear-screen. Exports the cursor position.
// Revision : 1.0 - initial release
// ============================================================================
module vga_text_console_writer #(
  parameter int          COLS      = 100,
  parameter int          ROWS      = 37,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        char_valid_in,
  input  logic [7:0]  char_in,
  output logic        char_ready_o,
  input  logic [7:0]  color_in,
  output logic        mem_valid_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic        mem_ready_in,
  input  logic [31:0] mem_rdata_in,
  output logic [6:0]  cursor_x_o,
  output logic [6:0]  cursor_y_o,
  output logic        busy_o
);

  localparam int              c_WORDS       = ROWS * COLS / 2;
  localparam int              c_ROW_WORDS   = COLS / 2;
  localparam int              c_CW          = $clog2(c_WORDS);
  localparam logic [c_CW-1:0] c_SCROLL_LAST = c_CW'((ROWS - 1) * COLS / 2 - 1);
  localparam logic [c_CW-1:0] c_FILL_LAST   = c_CW'(c_WORDS - 1);
  localparam logic [c_CW-1:0] c_CNT_ONE     = c_CW'(1);
  localparam logic [6:0]      c_LAST_COL    = 7'(COLS - 1);
  localparam logic [6:0]      c_LAST_ROW    = 7'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PUT       = 3'd1,
    S_NEWLINE   = 3'd2,
    S_SCROLL_RD = 3'd3,
    S_SCROLL_WR = 3'd4,
    S_FILL      = 3'd5
  } state_t;

  state_t            r_state, w_state_n;
  logic [6:0]        r_x, r_y, w_x_n, w_y_n;
  logic [c_CW-1:0]   r_cnt, w_cnt_n;
  logic              r_clr, w_clr_n;       // fill came from FF: home cursor at end
  logic [7:0]        r_color, w_color_n;   // attribute latched at command accept
  logic              r_valid, w_valid_n;
  logic              r_gap, w_gap_n;       // one idle bus cycle before next request
  logic [31:0]       r_addr, r_wdata, w_addr_n, w_wdata_n;
  logic [3:0]        r_wstrb, w_wstrb_n;
  logic              w_accept, w_done;
  logic [31:0]       w_cell;

  function automatic logic [31:0] word_addr(input logic [31:0] idx);
    return BASE_ADDR + {idx[29:0], 2'b00};
  endfunction

  function automatic logic [31:0] fill_word(input logic [7:0] col);
    return {col, 8'h20, col, 8'h20};
  endfunction

  assign w_accept = char_valid_in & char_ready_o;
  assign w_done   = r_valid & mem_ready_in;
  assign w_cell   = 32'(r_y) * 32'(COLS) + 32'(r_x);

  // Next-state, cursor and next-request computation
  always_comb begin
    w_state_n = r_state;
    w_x_n     = r_x;
    w_y_n     = r_y;
    w_cnt_n   = r_cnt;
    w_clr_n   = r_clr;
    w_color_n = r_color;
    w_valid_n = r_valid | r_gap;
    w_gap_n   = 1'b0;
    w_addr_n  = r_addr;
    w_wdata_n = r_wdata;
    w_wstrb_n = r_wstrb;
    case (r_state)
      S_IDLE: begin
        w_valid_n = 1'b0;
        if (w_accept) begin
          w_color_n = color_in;
          if (char_in >= 8'h20) begin
            w_state_n = S_PUT;
            w_valid_n = 1'b1;
            w_addr_n  = word_addr(w_cell >> 1);
            w_wdata_n = {color_in, char_in, color_in, char_in};
            w_wstrb_n = w_cell[0] ? 4'b1100 : 4'b0011;
          end else begin
            case (char_in)
              8'h0D: w_x_n = 7'd0;
              8'h0A: begin
                if (r_y < c_LAST_ROW) begin
                  w_y_n = r_y + 7'd1;
                end else begin
                  w_state_n = S_SCROLL_RD;
                  w_cnt_n   = '0;
                  w_clr_n   = 1'b0;
                  w_valid_n = 1'b1;
                  w_addr_n  = word_addr(32'(c_ROW_WORDS));
                  w_wdata_n = 32'h0;
                  w_wstrb_n = 4'b0000;
                end
              end
              8'h08: if (r_x != 7'd0) w_x_n = r_x - 7'd1;
              8'h0C: begin
                w_state_n = S_FILL;
                w_cnt_n   = '0;
                w_clr_n   = 1'b1;
                w_valid_n = 1'b1;
                w_addr_n  = word_addr(32'h0);
                w_wdata_n = fill_word(color_in);
                w_wstrb_n = 4'b1111;
              end
              default: ;
            endcase
          end
        end
      end
      S_PUT: begin
        if (w_done) begin
          w_valid_n = 1'b0;
          if (r_x == c_LAST_COL) begin
            w_x_n     = 7'd0;
            w_state_n = S_NEWLINE;
          end else begin
            w_x_n     = r_x + 7'd1;
            w_state_n = S_IDLE;
          end
        end
      end
      S_NEWLINE: begin
        // This cycle already serves as the bus gap after the PUT write.
        if (r_y < c_LAST_ROW) begin
          w_y_n     = r_y + 7'd1;
          w_state_n = S_IDLE;
        end else begin
          w_state_n = S_SCROLL_RD;
          w_cnt_n   = '0;
          w_clr_n   = 1'b0;
          w_valid_n = 1'b1;
          w_addr_n  = word_addr(32'(c_ROW_WORDS));
          w_wdata_n = 32'h0;
          w_wstrb_n = 4'b0000;
        end
      end
      S_SCROLL_RD: begin
        if (w_done) begin
          w_valid_n = 1'b0;
          w_gap_n   = 1'b1;
          w_state_n = S_SCROLL_WR;
          w_addr_n  = word_addr(32'(r_cnt));
          w_wdata_n = mem_rdata_in;
          w_wstrb_n = 4'b1111;
        end
      end
      S_SCROLL_WR: begin
        if (w_done) begin
          w_valid_n = 1'b0;
          w_gap_n   = 1'b1;
          w_cnt_n   = r_cnt + c_CNT_ONE;
          if (r_cnt == c_SCROLL_LAST) begin
            w_state_n = S_FILL;
            w_addr_n  = word_addr(32'(r_cnt) + 32'd1);
            w_wdata_n = fill_word(r_color);
            w_wstrb_n = 4'b1111;
          end else begin
            w_state_n = S_SCROLL_RD;
            w_addr_n  = word_addr(32'(r_cnt) + 32'(c_ROW_WORDS) + 32'd1);
            w_wdata_n = 32'h0;
            w_wstrb_n = 4'b0000;
          end
        end
      end
      S_FILL: begin
        if (w_done) begin
          w_valid_n = 1'b0;
          if (r_cnt == c_FILL_LAST) begin
            w_state_n = S_IDLE;
            if (r_clr) begin
              w_x_n = 7'd0;
              w_y_n = 7'd0;
            end
          end else begin
            w_gap_n   = 1'b1;
            w_cnt_n   = r_cnt + c_CNT_ONE;
            w_addr_n  = word_addr(32'(r_cnt) + 32'd1);
            w_wdata_n = fill_word(r_color);
          end
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_valid_n = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state <= S_IDLE;
      r_x     <= 7'd0;
      r_y     <= 7'd0;
      r_cnt   <= '0;
      r_clr   <= 1'b0;
      r_color <= 8'h0;
      r_valid <= 1'b0;
      r_gap   <= 1'b0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_wstrb <= 4'b0000;
    end else begin
      r_state <= w_state_n;
      r_x     <= w_x_n;
      r_y     <= w_y_n;
      r_cnt   <= w_cnt_n;
      r_clr   <= w_clr_n;
      r_color <= w_color_n;
      r_valid <= w_valid_n;
      r_gap   <= w_gap_n;
      r_addr  <= w_addr_n;
      r_wdata <= w_wdata_n;
      r_wstrb <= w_wstrb_n;
    end
  end

  assign char_ready_o = (r_state == S_IDLE) & ~reset_in;
  assign mem_valid_o  = r_valid;
  assign mem_addr_o   = r_addr;
  assign mem_wdata_o  = r_wdata;
  assign mem_wstrb_o  = r_wstrb;
  assign cursor_x_o   = r_x;
  assign cursor_y_o   = r_y;
  assign busy_o       = (r_state != S_IDLE);

endmodule
`default_nettype wire
